posit_encode_pipe: RTL and testbench

POSIT_ENCODE_PIPE -- requirements
Module: posit_encode_pipe

---
 rtl/posit_encode_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_posit_encode_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe
//   Three-stage valid/ready pipeline that turns an expanded posit
//   ("eposit": special flags, sign, biased regime, exponent, fraction) into a
//   packed N-bit posit with round-to-nearest-even.
//     S1: regime decode (run bit, run length) and saturation check
//     S2: regime/exponent/fraction placement, guard and sticky extraction
//     S3: rounding, clamping, sign application, specials
//   Optional feature macro: POSIT_ENC_INEXACT_CNT_EN adds the 16-bit
//   saturating inexact_cnt output (count of rounded output transfers).
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   in_eposit    {inf, zero, sign, regime[RW-1:0], exp[ES-1:0], frac[FW-1:0]}
//   in_valid     in_eposit valid
//   in_ready     block accepts in_eposit this cycle
//   out_posit    encoded posit
//   out_valid    out_posit valid
//   out_ready    consumer accepts out_posit this cycle
//   inexact_cnt  rounded-output count (POSIT_ENC_INEXACT_CNT_EN only)
module posit_encode_pipe #(
  parameter int N  = 16,
  parameter int ES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(N)+ES+N+2:0]    in_eposit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0]                 out_posit,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef POSIT_ENC_INEXACT_CNT_EN
  ,
  output logic [15:0]                  inexact_cnt
`endif
);

  localparam int RW = $clog2(N) + 1;
  localparam int FW = N - 1;
  localparam int EW = 3 + RW + ES + FW;
  // Terminator bit + exponent + fraction, placed after the regime run.
  localparam int TW = 1 + ES + FW;
  // Wide enough that the longest run (N-1) shifts nothing off the bottom.
  localparam int SW = TW + N - 1;
  localparam logic [RW-1:0] KBIAS = RW'(N - 1);
  localparam logic [RW-1:0] RMAX  = RW'(2 * N - 3);

  // ---------------------------------------------------------------------------
  // Handshake: a stage may load when empty or when its content moves on.
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  always_comb begin
    rdy3 = ~v3 | out_ready;
    rdy2 = ~v2 | rdy3;
    rdy1 = ~v1 | rdy2;
  end

  assign in_ready  = rdy1;
  assign out_valid = v3;

  // ---------------------------------------------------------------------------
  // S1: regime decode
  // ---------------------------------------------------------------------------
  logic [RW-1:0] d_regime;
  logic [RW-1:0] d_run_len;
  logic          d_run_bit;
  logic          d_sat;

  always_comb begin
    d_regime  = in_eposit[ES+FW +: RW];
    // k >= 0 gives a run of k+1 ones; k < 0 gives a run of -k zeros.
    d_run_bit = (d_regime >= KBIAS);
    d_sat     = (d_regime > RMAX);
    if (d_run_bit) d_run_len = d_regime - KBIAS + RW'(1);
    else           d_run_len = KBIAS - d_regime;
  end

  logic          s1_inf, s1_zero, s1_sign, s1_sat, s1_run_bit;
  logic [RW-1:0] s1_run_len;
  logic [TW-1:0] s1_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
      s1_sign    <= 1'b0;
      s1_sat     <= 1'b0;
      s1_run_bit <= 1'b0;
      s1_run_len <= '0;
      s1_tail    <= '0;
    end else if (rdy1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_inf     <= in_eposit[EW-1];
        s1_zero    <= in_eposit[EW-2];
        s1_sign    <= in_eposit[EW-3];
        s1_sat     <= d_sat;
        s1_run_bit <= d_run_bit;
        s1_run_len <= d_run_len;
        // Terminator is the opposite of the run bit.
        s1_tail    <= {~d_run_bit, in_eposit[ES+FW-1:0]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: shift tail right by the run length, fill the vacated top with the
  // run bit; the top N-1 bits are the magnitude body, next is guard, the
  // remainder ORs into sticky.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] run_mask;
  logic [SW-1:0] sh_word;

  always_comb begin
    run_mask = ~({SW{1'b1}} >> s1_run_len);
    sh_word  = ({s1_tail, {(N-1){1'b0}}} >> s1_run_len)
             | (s1_run_bit ? run_mask : '0);
  end

  logic         s2_inf, s2_zero, s2_sign, s2_sat;
  logic [N-2:0] s2_body;
  logic         s2_guard, s2_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2        <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sat    <= 1'b0;
      s2_body   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        s2_inf    <= s1_inf;
        s2_zero   <= s1_zero;
        s2_sign   <= s1_sign;
        s2_sat    <= s1_sat;
        s2_body   <= sh_word[SW-1 -: N-1];
        s2_guard  <= sh_word[SW-N];
        s2_sticky <= |sh_word[SW-N-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round to nearest even, clamp to [minpos, maxpos], apply sign, specials
  // ---------------------------------------------------------------------------
  logic         round_up;
  logic [N-1:0] mag_sum;
  logic [N-2:0] mag;
  logic [N-1:0] f_posit;

  always_comb begin
    round_up = s2_guard & (s2_sticky | s2_body[0]);
    mag_sum  = {1'b0, s2_body} + {{(N-1){1'b0}}, round_up};
    if (s2_sat || mag_sum[N-1])
      mag = '1;
    else if (mag_sum[N-2:0] == '0)
      mag = {{(N-2){1'b0}}, 1'b1};
    else
      mag = mag_sum[N-2:0];

    if (s2_sign) f_posit = -{1'b0, mag};
    else         f_posit = {1'b0, mag};

    if (s2_inf)
      f_posit = {1'b1, {(N-1){1'b0}}};
    else if (s2_zero)
      f_posit = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3        <= 1'b0;
      out_posit <= '0;
    end else if (rdy3) begin
      v3 <= v2;
      if (v2) out_posit <= f_posit;
    end
  end

`ifdef POSIT_ENC_INEXACT_CNT_EN
  // ---------------------------------------------------------------------------
  // Inexact counter: specials and saturated values never count.
  // ---------------------------------------------------------------------------
  logic f_inexact;
  logic s3_inexact;

  assign f_inexact = ~s2_inf & ~s2_zero & ~s2_sat & (s2_guard | s2_sticky);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_inexact <= 1'b0;
    end else if (rdy3 && v2) begin
      s3_inexact <= f_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_cnt <= '0;
    end else if (v3 && out_ready && s3_inexact && (inexact_cnt != '1)) begin
      inexact_cnt <= inexact_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Testbench for posit_encode_pipe (N=8, ES=0): directed boundary cases plus
// randomized traffic with random backpressure, checked against a bit-string
// reference model and an in-order scoreboard.
module tb_posit_encode_pipe;
  localparam int N  = 8;
  localparam int ES = 0;
  localparam int RW = $clog2(N) + 1;
  localparam int FW = N - 1;
  localparam int EW = 3 + RW + ES + FW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [EW-1:0] in_eposit;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_posit;
  logic          out_valid;
  logic          out_ready;
`ifdef POSIT_ENC_INEXACT_CNT_EN
  logic [15:0]   inexact_cnt;
`endif

  posit_encode_pipe #(.N(N), .ES(ES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_eposit  (in_eposit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_posit  (out_posit),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef POSIT_ENC_INEXACT_CNT_EN
    ,
    .inexact_cnt(inexact_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  logic [N:0]   sb[$];          // {inexact, posit} in input order
  int unsigned  model_cnt = 0;
  logic         prev_stall = 1'b0;
  logic         seen_ov;
  logic [N-1:0] seen_posit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic inf, input logic zero, input logic sign,
                                       input logic [RW-1:0] regime, input logic [ES+FW-1:0] rest);
    return {inf, zero, sign, regime, rest};
  endfunction

  // Reference: write out the posit bit string (regime run, terminator,
  // exponent, fraction), cut it after N-1 bits and round arithmetically.
  function automatic logic [N:0] ref_enc(input logic [EW-1:0] e);
    int   regime, k, body, maxpos;
    logic guard, sticky, inx;
    logic bits[$];
    logic [N-1:0] p;
    maxpos = (1 << (N - 1)) - 1;
    regime = int'(e[ES+FW +: RW]);
    if (e[EW-1]) return {1'b0, 1'b1, {(N-1){1'b0}}};
    if (e[EW-2]) return '0;
    inx = 1'b0;
    if (regime > 2 * N - 3) begin
      body = maxpos;
    end else begin
      k = regime - (N - 1);
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = ES + FW - 1; i >= 0; i--) bits.push_back(e[i]);
      body = 0;
      for (int i = 0; i < N - 1; i++) body = body * 2 + int'(bits[i]);
      guard  = bits[N-1];
      sticky = 1'b0;
      for (int i = N; i < int'(bits.size()); i++) sticky = sticky | bits[i];
      if (guard && (sticky || (body % 2 == 1))) body++;
      if (body > maxpos) body = maxpos;
      if (body == 0) body = 1;
      inx = guard | sticky;
    end
    if (e[EW-3]) body = (1 << N) - body;
    p = N'(body);
    return {inx, p};
  endfunction

  // One clock cycle: drive at negedge, sample before the next posedge.
  task automatic cycle(input logic iv, input logic [EW-1:0] e, input logic ordy, output logic acc);
    logic [N:0] exp;
    in_valid  = iv;
    in_eposit = e;
    out_ready = ordy;
    #1;
`ifdef POSIT_ENC_INEXACT_CNT_EN
    check("cnt", 32'(inexact_cnt), 32'(model_cnt));
`endif
    if (prev_stall) check("hold_valid", 32'(out_valid), 32'd1);
    seen_ov    = out_valid;
    seen_posit = out_posit;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious", 32'(out_valid), 32'd0);
      end else begin
        check("data", 32'(out_posit), 32'(sb[0][N-1:0]));
        if (out_ready) begin
          exp = sb.pop_front();
          if (exp[N] && model_cnt < 65535) model_cnt++;
        end
      end
    end
    prev_stall = out_valid & ~out_ready;
    acc = iv & in_ready;
    if (acc) sb.push_back(ref_enc(e));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_posit", 32'(out_posit), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
`ifdef POSIT_ENC_INEXACT_CNT_EN
    check("rst_cnt", 32'(inexact_cnt), 32'd0);
`endif
    sb.delete();
    model_cnt  = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, '0, 1'b1, acc);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Send one item into an empty pipe and measure cycles until out_valid.
  task automatic send_expect(input string tag, input logic [EW-1:0] e, input logic [N-1:0] want);
    logic        acc;
    int unsigned lat;
    cycle(1'b1, e, 1'b1, acc);
    check({tag, "_acc"}, 32'(acc), 32'd1);
    lat     = 0;
    seen_ov = 1'b0;
    while (!seen_ov && lat < 10) begin
      cycle(1'b0, '0, 1'b1, acc);
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check(tag, 32'(seen_posit), 32'(want));
  endtask

  function automatic logic [EW-1:0] rand_eposit();
    logic [EW-1:0] e;
    e = EW'($urandom);
    e[EW-1] = ($urandom_range(0, 31) == 0);
    e[EW-2] = ($urandom_range(0, 15) == 0);
    return e;
  endfunction

  initial begin
    logic          acc;
    logic [EW-1:0] items[4];
    int unsigned   idx;
`ifdef POSIT_ENC_INEXACT_CNT_EN
    int unsigned   c0;
`endif
    in_valid  = 1'b0;
    in_eposit = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    do_reset();

    // Basic encodings and specials
    send_expect("one",     mk(1'b0, 1'b0, 1'b0, RW'(7), 7'h00), 8'h40);
    send_expect("neg_one", mk(1'b0, 1'b0, 1'b1, RW'(7), 7'h00), 8'hC0);
`ifdef POSIT_ENC_INEXACT_CNT_EN
    c0 = model_cnt;
`endif
    send_expect("nar",     mk(1'b1, 1'b1, 1'b0, RW'(7), 7'h00), 8'h80);
    send_expect("zero",    mk(1'b0, 1'b1, 1'b1, RW'(3), 7'h5A), 8'h00);
`ifdef POSIT_ENC_INEXACT_CNT_EN
    check("cnt_specials", 32'(inexact_cnt), 32'(c0));
    c0 = model_cnt;
`endif
    // Rounding and saturation near maxpos
    send_expect("tie_even", mk(1'b0, 1'b0, 1'b0, RW'(12), 7'h40), 8'h7E);
    send_expect("round_up", mk(1'b0, 1'b0, 1'b0, RW'(12), 7'h60), 8'h7F);
    send_expect("sat",      mk(1'b0, 1'b0, 1'b0, RW'(15), 7'h55), 8'h7F);
`ifdef POSIT_ENC_INEXACT_CNT_EN
    check("cnt_plus2", 32'(inexact_cnt), 32'(c0 + 2));
`endif
    send_expect("neg_sat",  mk(1'b0, 1'b0, 1'b1, RW'(14), 7'h00), 8'h81);
    send_expect("minpos",   mk(1'b0, 1'b0, 1'b0, RW'(0),  7'h00), 8'h01);

    // Backpressure: 4 back-to-back offers, consumer stalled for 6 cycles
    for (int i = 0; i < 4; i++) items[i] = mk(1'b0, 1'b0, i[0], RW'(5 + i), 7'(17 * i + 3));
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(idx < 4, items[idx[1:0]], 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepts", idx, 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 20 && (idx < 4 || sb.size() != 0); c++) begin
      cycle(idx < 4, items[idx[1:0]], 1'b1, acc);
      if (acc) idx++;
    end
    check("bp_all", idx, 32'd4);
    drain();

    // Full throughput with consumer always ready
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, rand_eposit(), 1'b1, acc);
      check("stream_acc", 32'(acc), 32'd1);
    end
    drain();

    // Reset with two items in flight
    cycle(1'b1, mk(1'b0, 1'b0, 1'b0, RW'(9), 7'h11), 1'b0, acc);
    cycle(1'b1, mk(1'b0, 1'b0, 1'b1, RW'(4), 7'h22), 1'b0, acc);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, 1'b1, acc);
      check("post_rst_idle", 32'(seen_ov), 32'd0);
    end
    send_expect("post_rst", mk(1'b0, 1'b0, 1'b0, RW'(7), 7'h00), 8'h40);

    // Random traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      cycle($urandom_range(0, 9) < 7, rand_eposit(), $urandom_range(0, 9) < 6, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
